// File: rtl/parity_serializer.sv
// Parallel-to-serial front end for the serial parity detector: shifts a word out
// on x one bit per clock, optionally appends an even-parity bit, then idles GAP cycles.
module parity_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             append_par,
    output logic             din_ready,
    output logic             x,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH + 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 32'sd1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP);
    localparam logic             NO_GAP   = (GAP == 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             par_q, par_d;
    logic             apar_q, apar_d;
    logic             x_q, x_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q, busy_d;
    logic             din_ready_s;
    logic             load_s;

    // Bit that goes out next from a word in shift order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 32'sd0) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Word with its head bit consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 32'sd0) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    // Handshake readiness; with no gap a new word may follow the frame's last bit directly.
    always_comb begin
        din_ready_s = 1'b0;
        if (!rst) begin
            din_ready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            din_ready_s = 1'b1;
        end else if (NO_GAP) begin
            din_ready_s = frame_end_q;
        end else begin
            din_ready_s = 1'b0;
        end
    end

    assign load_s = din_ready_s & din_valid;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        par_d         = par_q;
        x_d           = 1'b0;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        busy_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    x_d         = head_bit(sreg_q);
                    bit_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    frame_end_d = (cnt_q == CNT_PEN) && !apar_q;
                    sreg_d      = advance(sreg_q);
                    cnt_d       = cnt_q + CNT_ONE;
                    par_d       = par_q ^ head_bit(sreg_q);
                end else if (apar_q) begin
                    // par_q now holds the XOR of every data bit, which makes the frame even.
                    state_d     = ST_PAR;
                    x_d         = par_q;
                    bit_valid_d = 1'b1;
                    frame_end_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = NO_GAP ? ST_IDLE : ST_GAP;
                    gap_d   = NO_GAP ? 4'd0 : 4'd1;
                    busy_d  = !NO_GAP;
                end
            end
            ST_PAR: begin
                state_d = NO_GAP ? ST_IDLE : ST_GAP;
                gap_d   = NO_GAP ? 4'd0 : 4'd1;
                busy_d  = !NO_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = 4'd0;
                end else begin
                    gap_d  = gap_q + 4'd1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // An accepted word overrides whatever the frame end decided.
        if (load_s) begin
            state_d       = ST_SHIFT;
            sreg_d        = advance(din);
            cnt_d         = CNT_ONE;
            gap_d         = 4'd0;
            par_d         = head_bit(din);
            apar_d        = append_par;
            x_d           = head_bit(din);
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            frame_end_d   = 1'b0;
            busy_d        = 1'b1;
        end else begin
            apar_d = apar_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            sreg_q        <= {WIDTH{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            gap_q         <= 4'd0;
            par_q         <= 1'b0;
            apar_q        <= 1'b0;
            x_q           <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            par_q         <= par_d;
            apar_q        <= apar_d;
            x_q           <= x_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
        end
    end

    assign din_ready   = din_ready_s;
    assign x           = x_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: two instances (LSB-first/GAP=1 and MSB-first/GAP=0)
// checked cycle by cycle against a frame-level expected-output queue.
module tb_parity_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         append_par = 1'b0;
    logic         sel = 1'b0;

    logic dv0, rdy0, x0, bv0, fs0, fe0, bz0;
    logic dv1, rdy1, x1, bv1, fs1, fe1, bz1;
    logic [4:0] obs;
    logic       obs_rdy;

    assign dv0     = din_valid & ~sel;
    assign dv1     = din_valid & sel;
    assign obs     = sel ? {x1, bv1, fs1, fe1, bz1} : {x0, bv0, fs0, fe0, bz0};
    assign obs_rdy = sel ? rdy1 : rdy0;

    always #5 clk = ~clk;

    parity_serializer #(.WIDTH(W), .MSB_FIRST(0), .GAP(1)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(dv0), .append_par(append_par),
        .din_ready(rdy0), .x(x0), .bit_valid(bv0), .frame_start(fs0),
        .frame_end(fe0), .busy(bz0)
    );

    parity_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP(0)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(dv1), .append_par(append_par),
        .din_ready(rdy1), .x(x1), .bit_valid(bv1), .frame_start(fs1),
        .frame_end(fe1), .busy(bz1)
    );

    // Expected cycles, each {x, bit_valid, frame_start, frame_end, busy}.
    logic [4:0] pend[$];
    logic [4:0] cur = 5'b0;
    int         m_gap = 1;
    bit         m_msb = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_acc = 0;
    int         run = 0;
    int         max_run = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready();
        return (pend.size() == 0) && ((cur[0] == 1'b0) || ((m_gap == 0) && cur[1]));
    endfunction

    task automatic push_frame(input logic [W-1:0] d, input logic ap);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = m_msb ? d[W-1-i] : d[i];
            pend.push_back({b, 1'b1, 1'(i == 0), 1'(i == W - 1 && !ap), 1'b1});
        end
        if (ap) pend.push_back({^d, 1'b1, 1'b0, 1'b1, 1'b1});
        for (int g = 0; g < m_gap; g++) pend.push_back(5'b00001);
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ap);
        @(negedge clk);
        check_eq("outs", 32'(obs), 32'(cur));
        check_eq("ready", 32'(obs_rdy), 32'(model_ready()));
        if (obs[3]) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        din        = d;
        append_par = ap;
        din_valid  = v;
        if (v && model_ready()) begin
            push_frame(d, ap);
            n_acc++;
        end
        @(posedge clk);
        if (pend.size() != 0) cur = pend.pop_front();
        else cur = 5'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        check_eq("pre_rst_outs", 32'(obs), 32'(cur));
        #2 rst = 1'b0;
        #1;
        check_eq("rst_x_bv_busy", 32'({obs[4], obs[3], obs[0]}), 32'd0);
        check_eq("rst_ready", 32'(obs_rdy), 32'd0);
        #1 rst = 1'b1;
        pend.delete();
        cur = 5'b0;
        din_valid = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", 32'(obs), 32'd0);
        check_eq("reset_ready", 32'(obs_rdy), 32'd0);
        rst = 1'b1;
        @(posedge clk);

        // LSB first, GAP=1
        cycle(1'b1, 8'hA5, 1'b1);
        idle(12);
        cycle(1'b1, 8'h07, 1'b0);
        idle(11);
        cycle(1'b1, 8'h11, 1'b1);
        idle(2);
        cycle(1'b1, 8'h3C, 1'b0);
        idle(12);
        cycle(1'b1, 8'h5A, 1'b1);
        idle(3);
        mid_reset();
        cycle(1'b1, 8'hC3, 1'b1);
        idle(12);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom));
        idle(15);

        // MSB first, GAP=0
        sel   = 1'b1;
        m_msb = 1'b1;
        m_gap = 0;
        cycle(1'b1, 8'h07, 1'b1);
        idle(12);
        max_run = 0;
        run     = 0;
        n_acc   = 0;
        for (int i = 0; i < 22; i++)
            cycle(1'(n_acc < 2), (n_acc == 0) ? 8'h01 : 8'hFF, 1'b1);
        idle(4);
        check_eq("b2b_run", 32'(max_run), 32'd18);
        cycle(1'b1, 8'h96, 1'b0);
        idle(3);
        mid_reset();
        cycle(1'b1, 8'h69, 1'b1);
        idle(12);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom));
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
